mem_sum_sequencer: RTL and testbench

//  Sequences the ALU/RegFile/Mem datapath to sum a block of RAM words.
//  On start: reads LEN words from Mem port B starting at BASE, accumulates them in a RegFile register via the ALU (add).

---
 rtl/seq_pkg.sv | 20 ++
 rtl/seq_addr_gen.sv | 48 ++++
 rtl/mem_sum_sequencer.sv | 142 ++++++++++++++
 tb/tb_mem_sum_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and defaults for the memory-sum sequencer.
// State encoding, ALU opcode and datapath width defaults.
package seq_pkg;

  localparam int AW_DEF = 6;
  localparam int DW_DEF = 32;

  localparam logic [4:0] ALU_OP_ADD  = 5'h1;
  localparam logic [4:0] ACC_REG_DEF = 5'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_READ,
    S_ACC,
    S_WRITE,
    S_DONE
  } state_t;

endpackage

// File: rtl/seq_addr_gen.sv
// Source pointer and word counter for the sum sequencer.
// Loads base/len on start, then steps once per accumulated word.
module seq_addr_gen
  import seq_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic [AW-1:0] ptr,
  output logic [AW:0]   cnt
);

  localparam logic [AW:0] MAX_LEN =
    {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] PTR_ONE =
    {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0] CNT_ONE =
    {{AW{1'b0}}, 1'b1};

  logic [AW:0] len_sat;

  // Clamp the requested count to the memory depth
  always_comb begin
    len_sat = len;
    if (len > MAX_LEN)
      len_sat = MAX_LEN;
  end

  // Pointer wraps naturally at the top of memory
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (load) begin
      ptr <= base_addr;
      cnt <= len_sat;
    end else if (step) begin
      ptr <= ptr + PTR_ONE;
      cnt <= cnt - CNT_ONE;
    end
  end

endmodule

// File: rtl/mem_sum_sequencer.sv
// Datapath master that sums a block of RAM words.
// Accumulates in a RegFile register via the ALU, then stores it.
module mem_sum_sequencer
  import seq_pkg::*;
#(
  parameter logic [4:0] ACC_REG = ACC_REG_DEF,
  parameter int         AW      = AW_DEF,
  parameter int         DW      = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  input  logic [AW-1:0] dst_addr,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] addrb,
  input  logic [DW-1:0] doutb,
  output logic          wea,
  output logic [AW-1:0] addra,
  output logic [DW-1:0] dina,
  output logic [4:0]    r1_addr,
  input  logic [DW-1:0] r1_out,
  output logic [4:0]    r3_addr,
  output logic          r3_we,
  output logic [DW-1:0] r3_in,
  output logic [DW-1:0] ALU_A,
  output logic [DW-1:0] ALU_B,
  input  logic [DW-1:0] ALU_OUT
);

  localparam logic [AW:0] CNT_ONE =
    {{AW{1'b0}}, 1'b1};

  state_t        state;
  state_t        nxt;
  logic [AW-1:0] ptr;
  logic [AW:0]   cnt;
  logic [AW-1:0] dst;
  logic [AW-1:0] addrb_q;
  logic          load;
  logic          step;

  assign load    = (state == S_IDLE) && start;
  assign step    = (state == S_ACC);
  assign r1_addr = ACC_REG;
  assign r3_addr = ACC_REG;

  seq_addr_gen #(
    .AW (AW)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .base_addr (base_addr),
    .len       (len),
    .ptr       (ptr),
    .cnt       (cnt)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= nxt;
  end

  // Latch destination; remember last read address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst     <= '0;
      addrb_q <= '0;
    end else begin
      if (load)
        dst <= dst_addr;
      if (state == S_READ)
        addrb_q <= ptr;
    end
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (start) nxt = S_CLEAR;
      S_CLEAR: nxt = (cnt == '0) ? S_WRITE
                                 : S_READ;
      S_READ:  nxt = S_ACC;
      S_ACC:   nxt = (cnt == CNT_ONE) ? S_WRITE
                                      : S_READ;
      S_WRITE: nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Output decode purely from the state register
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    wea   = 1'b0;
    addra = '0;
    dina  = '0;
    r3_we = 1'b0;
    r3_in = '0;
    ALU_A = '0;
    ALU_B = '0;
    addrb = addrb_q;
    unique case (1'b1)
      (state == S_CLEAR): begin
        busy  = 1'b1;
        r3_we = 1'b1;
      end
      (state == S_READ): begin
        busy  = 1'b1;
        addrb = ptr;
      end
      (state == S_ACC): begin
        busy  = 1'b1;
        ALU_A = r1_out;
        ALU_B = doutb;
        r3_in = ALU_OUT;
        r3_we = 1'b1;
      end
      (state == S_WRITE): begin
        busy  = 1'b1;
        wea   = 1'b1;
        addra = dst;
        dina  = r1_out;
      end
      (state == S_DONE): begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_sum_sequencer.sv
// Directed bench for mem_sum_sequencer.
// Models Mem, RegFile and ALU around the sequencer.
module tb_mem_sum_sequencer;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic [AW-1:0] dst_addr = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] addrb;
  logic [DW-1:0] doutb;
  logic          wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic [4:0]    r1_addr;
  logic [DW-1:0] r1_out;
  logic [4:0]    r3_addr;
  logic          r3_we;
  logic [DW-1:0] r3_in;
  logic [DW-1:0] ALU_A;
  logic [DW-1:0] ALU_B;
  logic [DW-1:0] ALU_OUT;

  logic [DW-1:0] mem [64];
  logic [DW-1:0] rf [32];
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_wa = '0;
  logic [DW-1:0] tb_wd = '0;

  int n_chk  = 0;
  int n_pass = 0;
  int lat;
  int nbusy;
  int nmove;

  always #5 clk = ~clk;

  mem_sum_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .dst_addr  (dst_addr),
    .busy      (busy),
    .done      (done),
    .addrb     (addrb),
    .doutb     (doutb),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .r1_addr   (r1_addr),
    .r1_out    (r1_out),
    .r3_addr   (r3_addr),
    .r3_we     (r3_we),
    .r3_in     (r3_in),
    .ALU_A     (ALU_A),
    .ALU_B     (ALU_B),
    .ALU_OUT   (ALU_OUT)
  );

  always @(posedge clk) begin
    doutb <= mem[addrb];
    if (wea)
      mem[addra] <= dina;
    else if (tb_we)
      mem[tb_wa] <= tb_wd;
  end

  always @(posedge clk)
    if (r3_we && r3_addr != 5'd0)
      rf[r3_addr] <= r3_in;

  assign r1_out  = (r1_addr == 5'd0) ? '0
                                     : rf[r1_addr];
  assign ALU_OUT = ALU_A + ALU_B;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
  endtask

  task automatic mem_put(input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    @(negedge clk);
    tb_we = 1'b1;
    tb_wa = a;
    tb_wd = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Pulse start; poke>0 re-pulses start in that cycle
  task automatic run(input logic [AW-1:0] b,
                     input logic [AW:0]   l,
                     input logic [AW-1:0] d,
                     input int            poke,
                     output int           lat_o,
                     output int           busy_o,
                     output int           move_o);
    logic [AW-1:0] a0;
    lat_o  = -1;
    busy_o = 0;
    move_o = 0;
    @(negedge clk);
    a0        = addrb;
    base_addr = b;
    len       = l;
    dst_addr  = d;
    start     = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (k == poke) begin
        base_addr = 6'd30;
        len       = 7'd1;
        dst_addr  = 6'd40;
        start     = 1'b1;
      end
      if (busy) busy_o++;
      if (addrb != a0) move_o++;
      if (done) begin
        lat_o = k;
        break;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wea", wea, 0);
    chk("rst_r3we", r3_we, 0);
    chk("rst_addrb", addrb, 0);
    chk("rst_addra", addra, 0);
    chk("rst_dina", dina, 0);
    chk("rst_r3in", r3_in, 0);
    chk("r1_addr", r1_addr, 1);
    chk("r3_addr", r3_addr, 1);
    @(negedge clk);
    rst = 1'b0;

    // 1: basic sum of four words
    for (int i = 0; i < 4; i++)
      mem_put(i[5:0], i + 1);
    mem_put(6'd10, 32'hAAAA);
    run(6'd0, 7'd4, 6'd10, 0, lat, nbusy, nmove);
    chk("t1_lat", lat, 11);
    chk("t1_busy", nbusy, 10);
    chk("t1_mem", mem[10], 10);
    chk("t1_rf", rf[1], 10);

    // 2: zero length writes zero, no reads
    mem_put(6'd5, 32'h55);
    run(6'd7, 7'd0, 6'd5, 0, lat, nbusy, nmove);
    chk("t2_lat", lat, 3);
    chk("t2_mem", mem[5], 0);
    chk("t2_moves", nmove, 0);
    chk("t2_busy", nbusy, 2);

    // 3: source range wraps 63 -> 0
    mem_put(6'd62, 5);
    mem_put(6'd63, 6);
    mem_put(6'd0, 7);
    mem_put(6'd1, 8);
    run(6'd62, 7'd4, 6'd11, 0, lat, nbusy, nmove);
    chk("t3_lat", lat, 11);
    chk("t3_mem", mem[11], 26);

    // 4a: sum wraps mod 2^32
    mem_put(6'd0, 32'hFFFF_FFFF);
    mem_put(6'd1, 2);
    run(6'd0, 7'd2, 6'd12, 0, lat, nbusy, nmove);
    chk("t4_lat", lat, 7);
    chk("t4_wrap", mem[12], 1);

    // 4b: len beyond depth saturates to 64
    for (int i = 0; i < 64; i++)
      mem_put(i[5:0], 1);
    run(6'd0, 7'd100, 6'd63, 0, lat, nbusy, nmove);
    chk("t4_sat_lat", lat, 131);
    chk("t4_sat_mem", mem[63], 64);

    // 5a: start while busy is ignored
    for (int i = 0; i < 4; i++)
      mem_put(i[5:0], i + 1);
    run(6'd0, 7'd4, 6'd13, 4, lat, nbusy, nmove);
    chk("t5_lat", lat, 11);
    chk("t5_mem", mem[13], 10);
    repeat (10) @(posedge clk);
    #1;
    chk("t5_idle", busy, 0);
    chk("t5_nodst", mem[40], 1);

    // 5b: reset while accumulating aborts
    mem_put(6'd20, 32'hDEAD_BEEF);
    @(negedge clk);
    base_addr = 6'd0;
    len       = 7'd4;
    dst_addr  = 6'd20;
    start     = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk("t5_inacc", r3_we, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ab_busy", busy, 0);
    chk("ab_r3we", r3_we, 0);
    chk("ab_wea", wea, 0);
    chk("ab_addrb", addrb, 0);
    chk("ab_r3in", r3_in, 0);
    chk("ab_aluab", ALU_A | ALU_B, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("ab_dst", mem[20], 32'hDEAD_BEEF);
    chk("ab_idle", busy, 0);

    // 6: destination overlaps source
    mem_put(6'd0, 3);
    mem_put(6'd1, 4);
    run(6'd0, 7'd2, 6'd0, 0, lat, nbusy, nmove);
    chk("t6_lat", lat, 7);
    chk("t6_mem", mem[0], 7);
    chk("t6_rf", rf[1], 7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
